// File: rtl/score_keeper_if.sv
// Game-side signal bundle for the score keeper: controller/collision inputs
// in one direction, display and status outputs in the other.
interface score_keeper_if;
  logic        start;
  logic        hit;
  logic        miss;
  logic [15:0] grade;
  logic [15:0] elapsed;
  logic [2:0]  lives_left;
  logic        lose;
  logic        playing;

  // Game controller / collision logic side
  modport master (
    output start, hit, miss,
    input  grade, elapsed, lives_left, lose, playing
  );

  // Score keeper side
  modport slave (
    input  start, hit, miss,
    output grade, elapsed, lives_left, lose, playing
  );
endinterface

// File: rtl/score_keeper.sv
// Score keeper for a paddle game: counts paddle hits (grade), whole seconds
// of play (elapsed) and remaining lives, and flags the end of the game.
// All outputs come straight from registers.
module score_keeper #(
  parameter int CLK_HZ  = 100000000,
  parameter int LIVES   = 3,
  parameter int MAX_CNT = 9999
) (
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave bus
);

  localparam int          PRE_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [15:0] CNT_MAX    = 16'(MAX_CNT);
  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    LOST = 2'd2
  } state_t;

  state_t           state;
  logic [15:0]      grade_q;
  logic [15:0]      elapsed_q;
  logic [2:0]       lives_q;
  logic             lose_q;
  logic             playing_q;
  logic [PRE_W-1:0] presc;

  logic rst_meta;
  logic rst_sync;

  logic start_p0;
  logic hit_p0;
  logic miss_p0;
  logic start_rise;
  logic hit_rise;
  logic miss_rise;

  // Counter increment that sticks at the 4-digit display limit.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v >= CNT_MAX) return CNT_MAX;
    return v + 16'd1;
  endfunction

  // Reset assertion is immediate; release is retimed through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

  // ---- stage p0: capture input levels for rising-edge detection ----
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      start_p0 <= 1'b0;
      hit_p0   <= 1'b0;
      miss_p0  <= 1'b0;
    end else begin
      start_p0 <= bus.start;
      hit_p0   <= bus.hit;
      miss_p0  <= bus.miss;
    end
  end

  // A level held high produces one edge only: its first cycle.
  assign start_rise = bus.start & ~start_p0;
  assign hit_rise   = bus.hit   & ~hit_p0;
  assign miss_rise  = bus.miss  & ~miss_p0;

  // ---- stage p1: game FSM with registered counters and status flags ----
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state     <= IDLE;
      grade_q   <= 16'd0;
      elapsed_q <= 16'd0;
      lives_q   <= LIVES_INIT;
      lose_q    <= 1'b0;
      playing_q <= 1'b0;
      presc     <= '0;
    end else begin
      case (state)
        IDLE, LOST: begin
          // Scores hold and hit/miss are ignored until a new game starts.
          if (start_rise) begin
            state     <= PLAY;
            grade_q   <= 16'd0;
            elapsed_q <= 16'd0;
            lives_q   <= LIVES_INIT;
            presc     <= '0;
            lose_q    <= 1'b0;
            playing_q <= 1'b1;
          end
        end

        PLAY: begin
          if (hit_rise) grade_q <= sat_inc(grade_q);

          if (presc == PRE_LAST) begin
            presc     <= '0;
            elapsed_q <= sat_inc(elapsed_q);
          end else begin
            presc <= presc + 1'b1;
          end

          // A fatal miss ends the game; a simultaneous hit above still counts.
          if (miss_rise) begin
            if (lives_q <= 3'd1) begin
              lives_q   <= 3'd0;
              state     <= LOST;
              lose_q    <= 1'b1;
              playing_q <= 1'b0;
            end else begin
              lives_q <= lives_q - 3'd1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          lose_q    <= 1'b0;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grade      = grade_q;
  assign bus.elapsed    = elapsed_q;
  assign bus.lives_left = lives_q;
  assign bus.lose       = lose_q;
  assign bus.playing    = playing_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: the stimulus thread queues hand-computed
// expected output snapshots, a monitor thread pops and compares them on the
// falling clock edge.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst = 1'b0;

  score_keeper_if bus ();

  score_keeper #(
    .CLK_HZ (10),
    .LIVES  (3),
    .MAX_CNT(9999)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] grade;
    bit          chk_el;
    logic [15:0] elapsed;
    logic [2:0]  lives;
    logic        lose;
    logic        playing;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: compare every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests = tests + 1;
      if (bus.grade !== e.grade || bus.lives_left !== e.lives ||
          bus.lose !== e.lose || bus.playing !== e.playing ||
          (e.chk_el && bus.elapsed !== e.elapsed)) begin
        fails = fails + 1;
        $display("FAIL %s: got grade=%0d elapsed=%0d lives=%0d lose=%0b playing=%0b, want grade=%0d elapsed=%s lives=%0d lose=%0b playing=%0b",
                 e.name, bus.grade, bus.elapsed, bus.lives_left, bus.lose, bus.playing,
                 e.grade, e.chk_el ? $sformatf("%0d", e.elapsed) : "any",
                 e.lives, e.lose, e.playing);
      end
    end
  end

  // Queue an expectation for the next falling edge (el < 0: elapsed not checked).
  task automatic push(input string n, input int g, input int el, input int lv,
                      input bit ls, input bit pl);
    exp_t e;
    e.name    = n;
    e.grade   = 16'(g);
    e.chk_el  = (el >= 0);
    e.elapsed = 16'((el >= 0) ? el : 0);
    e.lives   = 3'(lv);
    e.lose    = ls;
    e.playing = pl;
    exp_q.push_back(e);
  endtask

  // Let one more clock pass, then queue the expectation.
  task automatic expect_state(input string n, input int g, input int el, input int lv,
                              input bit ls, input bit pl);
    @(posedge clk);
    #1;
    push(n, g, el, lv, ls, pl);
  endtask

  // One-cycle pulse on any combination of start/hit/miss.
  task automatic pulse(input bit s, input bit h, input bit m);
    @(posedge clk);
    #1;
    bus.start = s;
    bus.hit   = h;
    bus.miss  = m;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;

    // Reset values while rst is held low
    repeat (3) @(posedge clk);
    #1;
    push("reset_values", 0, 0, 3, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // IDLE ignores hit and miss
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    expect_state("idle_ignores", 0, 0, 3, 0, 0);

    // Start a game, then 5 hits
    pulse(1, 0, 0);
    expect_state("start_play", 0, 0, 3, 0, 1);
    for (int i = 0; i < 5; i++) pulse(0, 1, 0);
    expect_state("five_hits", 5, -1, 3, 0, 1);

    // Start edge during PLAY is ignored
    pulse(1, 0, 0);
    expect_state("start_in_play", 5, -1, 3, 0, 1);

    // Hit held high for 100 cycles counts once
    @(posedge clk);
    #1;
    bus.hit = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    bus.hit = 1'b0;
    expect_state("hit_held", 6, -1, 3, 0, 1);

    // Misses down to loss
    pulse(0, 0, 1);
    expect_state("miss_1", 6, -1, 2, 0, 1);
    pulse(0, 0, 1);
    expect_state("miss_2", 6, -1, 1, 0, 1);
    pulse(0, 0, 1);
    expect_state("miss_fatal", 6, -1, 0, 1, 0);
    pulse(0, 1, 0);
    expect_state("lost_ignores_hit", 6, -1, 0, 1, 0);

    // Elapsed seconds with CLK_HZ = 10: 32 cycles in PLAY gives 3
    pulse(1, 0, 0);
    repeat (31) @(posedge clk);
    expect_state("elapsed_3", 0, 3, 3, 0, 1);
    for (int i = 0; i < 3; i++) pulse(0, 0, 1);
    expect_state("elapsed_lost", 0, 3, 0, 1, 0);
    repeat (20) @(posedge clk);
    expect_state("elapsed_frozen", 0, 3, 0, 1, 0);

    // Simultaneous hit and fatal miss
    pulse(1, 0, 0);
    expect_state("restart", 0, 0, 3, 0, 1);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    expect_state("one_life", 0, -1, 1, 0, 1);
    pulse(0, 1, 1);
    expect_state("hit_and_fatal_miss", 1, -1, 0, 1, 0);

    // Grade saturation
    pulse(1, 0, 0);
    for (int i = 0; i < 9999; i++) pulse(0, 1, 0);
    expect_state("grade_at_max", 9999, -1, 3, 0, 1);
    pulse(0, 1, 0);
    expect_state("grade_saturated", 9999, -1, 3, 0, 1);

    // Asynchronous reset mid-game, observed before any further clock edge
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    for (int i = 0; i < 7; i++) pulse(0, 1, 0);
    expect_state("grade_7", 7, -1, 3, 0, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    push("async_reset", 0, 0, 3, 0, 0);
    #1;
    tests = tests + 1;
    if (bus.grade !== 16'd0 || bus.elapsed !== 16'd0 || bus.lives_left !== 3'd3 ||
        bus.lose !== 1'b0 || bus.playing !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL async_reset_immediate: grade=%0d elapsed=%0d lives=%0d lose=%0b playing=%0b",
               bus.grade, bus.elapsed, bus.lives_left, bus.lose, bus.playing);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    expect_state("after_reset_idle", 0, 0, 3, 0, 0);
    pulse(1, 0, 0);
    expect_state("start_after_reset", 0, 0, 3, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    tests = tests + 1;
    if (bus.grade !== 16'd0 || bus.lives_left !== 3'd3 || bus.lose !== 1'b0 ||
        bus.playing !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL final_state: grade=%0d lives=%0d lose=%0b playing=%0b",
               bus.grade, bus.lives_left, bus.lose, bus.playing);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, clock cycles per one-second tick.
REQ-002 The block SHALL have parameter LIVES, default 3, misses allowed before loss (1..7).
REQ-003 The block SHALL have parameter MAX_CNT, default 9999, saturation value of score and elapsed time (4-digit display limit).
REQ-004 The block SHALL have port clk, input, 1, 100 MHz system clock.
REQ-005 The block SHALL have port rst, input, 1, reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, level from the game controller; a rising edge begins a game.
REQ-007 The block SHALL have port hit, input, 1, level from collision logic; a rising edge means the ball bounced on the paddle.
REQ-008 The block SHALL have port miss, input, 1, level from collision logic; a rising edge means the ball fell past the paddle.
REQ-009 The block SHALL have port grade, output, 16, binary score feeding the seven-segment display.
REQ-010 The block SHALL have port elapsed, output, 16, binary whole seconds of play feeding the seven-segment display.
REQ-011 The block SHALL have port lives_left, output, 3, remaining lives.
REQ-012 The block SHALL have port lose, output, 1, high while the game is over.
REQ-013 The block SHALL have port playing, output, 1, high while in PLAY.

Function
REQ-014 The block SHALL register start, hit and miss once and detect rising edges against the registered value; an input held high SHALL count once only.
REQ-015 The FSM SHALL have states IDLE, PLAY and LOST.
REQ-016 IDLE: start edge -> PLAY next cycle; grade, elapsed = 0 and lives_left = LIVES are loaded in that same cycle.
REQ-017 PLAY: each hit edge SHALL increment grade by 1 one cycle after the edge is detected, saturating at MAX_CNT.
REQ-018 PLAY: each miss edge SHALL decrement lives_left by 1; a miss while lives_left == 1 SHALL set lives_left = 0 and move to LOST.
REQ-019 PLAY: hit and miss edges in the same cycle SHALL apply both the increment and the decrement; if the miss is fatal, the hit still counts.
REQ-020 PLAY: a prescaler SHALL count 0..CLK_HZ-1 and increment elapsed on wrap, saturating at MAX_CNT; the prescaler SHALL clear on entry to PLAY.
REQ-021 LOST: grade and elapsed SHALL freeze, and hit and miss SHALL be ignored; a start edge SHALL restart as in REQ-016 (LOST -> PLAY).
REQ-022 PLAY: a start edge SHALL be ignored.
REQ-023 IDLE: hit and miss SHALL be ignored, and grade and elapsed SHALL hold.
REQ-024 lose SHALL be 1 exactly in LOST, and playing SHALL be 1 exactly in PLAY; both are registered outputs decoded from the state register.
REQ-025 All outputs SHALL be registered with no combinational path from input to output.

Reset
REQ-026 While rst = 0, the FSM SHALL be in IDLE, and grade = 0, elapsed = 0, lives_left = LIVES, lose = 0, playing = 0, with the prescaler and edge registers cleared, regardless of clk.
REQ-027 Release of rst SHALL be synchronised internally with a 2-flop deassertion synchroniser; assertion SHALL take effect immediately.
REQ-028 Reset asserted mid-game SHALL abandon the game; no partial count persists.

Verification
REQ-029 Bench: reset, then start pulse, then 5 hit pulses -> playing = 1, grade = 5, lives_left = 3, lose = 0.
REQ-030 Bench: with CLK_HZ = 10, hold PLAY for 35 cycles -> elapsed = 3; then 3 miss pulses -> lose = 1, lives_left = 0, and elapsed stays frozen at 3.
REQ-031 Bench: hit held high for 100 cycles -> grade increments by 1 only.
REQ-032 Bench: lives_left = 1 and hit plus miss edges in the same cycle -> grade + 1, lives_left = 0, lose = 1.
REQ-033 Bench: preload grade to MAX_CNT via 9999 hits, then 1 more hit -> grade stays 9999.
REQ-034 Bench: assert rst low asynchronously mid-game (grade = 7) -> all outputs go to reset values within the same cycle; start after release -> grade = 0.
